// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and common constants.
// Imported by the receiver now and by the transmitter later.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer.
// The reset value is a parameter so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid/ferr strobes.
// A framing error parks the FSM until the line returns high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      valid,
    output logic                      ferr,
    output logic                      busy
);

    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LP_BLAST = BIT_W'(UART_DATA_BITS - 1);

    uart_rx_state_t              r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [BIT_W-1:0]            r_bit;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [UART_DATA_BITS-1:0]   r_dout;
    logic                        r_valid;
    logic                        r_ferr;

    uart_rx_state_t              w_state_nxt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [CNT_W-1:0]            w_cnt_inc;
    logic [BIT_W-1:0]            w_bit_nxt;
    logic [UART_DATA_BITS-1:0]   w_shift_nxt;
    logic [UART_DATA_BITS-1:0]   w_dout_nxt;
    logic                        w_valid_nxt;
    logic                        w_ferr_nxt;
    logic                        w_rxd_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxd_s)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_dout_nxt  = r_dout;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (!w_rxd_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was noise.
                if (r_cnt == LP_HALF) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rxd_s ? IDLE : DATA;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            DATA: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_bit] = w_rxd_s;
                    if (r_bit == LP_BLAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            STOP: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rxd_s) begin
                        w_dout_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            BREAK: begin
                // Held-low line must return high before a new frame can start.
                w_cnt_nxt = '0;
                if (w_rxd_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign dout  = r_dout;
    assign valid = r_valid;
    assign ferr  = r_ferr;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model with scheduled strobes.
// Directed scenarios plus randomized byte streams with framing errors.
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] dout;
    logic       valid;
    logic       ferr;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [7:0] exp_v [int];
    bit         exp_f [int];
    logic [7:0] m_dout = 8'h00;

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         last_valid_cyc = 0;
    int         last_fall = 0;
    logic [31:0] word = 32'h0;
    int         wcnt = 0;
    bit         prev_strobe = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .dout  (dout),
        .valid (valid),
        .ferr  (ferr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Cycle count and reset effect on the model: reset drops every
    // strobe not yet observed and clears the held byte.
    always @(posedge clk) begin
        int ks[$];
        cyc = cyc + 1;
        if (rst) begin
            m_dout = 8'h00;
            ks = {};
            foreach (exp_v[k]) if (k >= cyc) ks.push_back(k);
            foreach (ks[i]) exp_v.delete(ks[i]);
            ks = {};
            foreach (exp_f[k]) if (k >= cyc) ks.push_back(k);
            foreach (ks[i]) exp_f.delete(ks[i]);
        end
    end

    always @(negedge clk) begin
        bit ev;
        bit ef;
        if (chk_en) begin
            ev = exp_v.exists(cyc);
            ef = exp_f.exists(cyc);
            if (ev) begin
                m_dout = exp_v[cyc];
                exp_v.delete(cyc);
            end
            if (ef) exp_f.delete(cyc);
            chk("valid", {31'b0, valid}, {31'b0, ev});
            chk("ferr", {31'b0, ferr}, {31'b0, ef});
            chk("dout", {24'b0, dout}, {24'b0, m_dout});
            if (prev_strobe && (valid || ferr)) begin
                chk("strobe_spacing", 32'd1, 32'd0);
            end
            prev_strobe = valid || ferr;
            if (valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                word = {dout, word[31:8]};
                wcnt++;
            end
            if (ferr === 1'b1) n_ferr++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit good,
                              input int hold, input bit abort);
        logic [9:0] f;
        f = {good, b, 1'b0};
        last_fall = cyc;
        if (good) exp_v[cyc + LAT] = b;
        else exp_f[cyc + LAT] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            if (abort && i == 5) begin
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        if (!good) begin
            repeat (hold) @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    initial begin
        int nv;
        int nf;
        logic [7:0] b;
        bit good;
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("reset_busy", {31'b0, busy}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte with latency from raw line fall.
        nv = n_valid;
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("a5_count", n_valid - nv, 32'd1);
        chk("a5_latency", last_valid_cyc - last_fall, 32'd79);
        chk("a5_dout", {24'b0, dout}, 32'h0000_00A5);
        chk("a5_idle", {31'b0, busy}, 32'd0);

        // Back-to-back frames feeding a little-endian word assembler.
        nv = n_valid;
        wcnt = 0;
        send_frame(8'h78, 1'b1, 0, 1'b0);
        send_frame(8'h56, 1'b1, 0, 1'b0);
        send_frame(8'h34, 1'b1, 0, 1'b0);
        send_frame(8'h12, 1'b1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("b2b_count", n_valid - nv, 32'd4);
        chk("b2b_words", wcnt, 32'd4);
        chk("b2b_word", word, 32'h1234_5678);

        // Start glitch.
        nv = n_valid;
        nf = n_ferr;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy", {31'b0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        chk("glitch_idle", {31'b0, busy}, 32'd0);
        chk("glitch_nov", n_valid - nv, 32'd0);
        chk("glitch_nof", n_ferr - nf, 32'd0);

        // Framing error, long break, then a good byte.
        nv = n_valid;
        nf = n_ferr;
        send_frame(8'h3C, 1'b0, 32, 1'b0);
        repeat (16) @(negedge clk);
        chk("ferr_count", n_ferr - nf, 32'd1);
        chk("ferr_nov", n_valid - nv, 32'd0);
        chk("ferr_idle", {31'b0, busy}, 32'd0);
        send_frame(8'h81, 1'b1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("ferr_next", {24'b0, dout}, 32'h0000_0081);
        chk("ferr_next_cnt", n_valid - nv, 32'd1);

        // Reset during bit 4 of 0xFF, then a good byte.
        nv = n_valid;
        send_frame(8'hFF, 1'b1, 0, 1'b1);
        chk("abort_nov", n_valid - nv, 32'd0);
        chk("abort_dout", {24'b0, dout}, 32'd0);
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_next", {24'b0, dout}, 32'h0000_000F);
        chk("abort_cnt", n_valid - nv, 32'd1);

        // Randomized stream with occasional framing errors.
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 99) >= 15);
            if (good) begin
                send_frame(b, 1'b1, 0, 1'b0);
                repeat ($urandom_range(0, 16)) @(negedge clk);
            end else begin
                send_frame(b, 1'b0, $urandom_range(0, 24), 1'b0);
                repeat ($urandom_range(8, 16)) @(negedge clk);
            end
        end

        repeat (100) @(negedge clk);
        chk("pending", exp_v.size() + exp_f.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive front end for the host-load path. It deserialises an asynchronous 8N1 UART line into bytes and emits a one-cycle valid strobe per byte. Its dout/valid pair drives the byte-to-word concatenation stage directly: valid connects to that stage's en, dout to its din. It runs in the single core clock domain; rxd is the only asynchronous input.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter.

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial line, idle high
dout  output  8  last received byte, LSB is the first data bit on the line
valid  output  1  one-cycle pulse: dout holds a new good byte
ferr  output  1  one-cycle pulse: framing error (stop bit sampled low)
busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset values: dout=8'h00, valid=0, ferr=0, busy=0, state=IDLE, counters=0.
- rst wins over every other event. Asserting rst mid-frame drops the frame: no valid, no ferr, back to IDLE next cycle.
- rxd passes through a 2-FF synchronizer (rxd_s). All logic uses rxd_s only. Raw-to-rxd_s latency is 2 cycles.
- Sample counter: counts 0..CLKS_PER_BIT-1 and wraps to 0.
- Bit index: counts 0..7.
- IDLE: when rxd_s==0, go to START and clear the sample counter.
- START: at sample count (CLKS_PER_BIT/2)-1 (mid start bit):
  - rxd_s==0: go to DATA, clear counter and bit index.
  - rxd_s==1: glitch; return to IDLE with no output.
- DATA: at each count CLKS_PER_BIT-1 (mid data bit), shift rxd_s into shift reg bit [bit index], LSB first.
  - After bit 7, go to STOP.
- STOP: at count CLKS_PER_BIT-1 (mid stop bit):
  - rxd_s==1: dout<=shift reg, valid=1 for exactly the next cycle, go to IDLE.
  - rxd_s==0: ferr=1 for one cycle, dout unchanged, go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. A line held low never retriggers a frame.
- Latency: valid asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after rxd_s first falls. Add 2 cycles when measuring from raw rxd.
- valid and ferr are mutually exclusive and never high on consecutive cycles.
- dout holds its value until the next valid.
- Back-to-back frames: the next start bit's falling edge can occur half a bit after the stop sample. IDLE is re-entered in time, so no frame is lost at the nominal rate. Receiver tolerance is ±4% clock mismatch.
- No backpressure: the consumer must accept on every valid pulse. The concat stage always does.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - localparam UART_DATA_BITS = 8
  - default CLKS_PER_BIT constant, shared with the future uart_tx
- Sub-module sync_2ff: generic 1-bit two-flop synchronizer; the reset value is a parameter (1 here).
- FSM, counters and shift register stay in uart_rx.

Test Plan:
Simulation uses CLKS_PER_BIT=8.
- Reset: hold rst 5 cycles with rxd=1 -> dout=00, valid=0, ferr=0, busy=0 throughout.
- Single byte: send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one valid pulse, dout=A5, cycle count from rxd fall = 2+4+72+1 = 79.
- Back-to-back: four frames 0x78,0x56,0x34,0x12 with no idle gap -> four valid pulses. Feeding the concat stage yields a 32-bit word 0x12345678 with its valid.
- Start glitch: rxd low for 2 cycles, then high -> no valid, no ferr, busy drops back to 0 within 8 cycles.
- Framing error: send 0x3C with stop bit 0, hold rxd low 40 cycles, then high, then send 0x81 -> one ferr pulse, no valid for the first frame, then valid with dout=81.
- Reset mid-frame: assert rst during bit 4 of 0xFF, then send 0x0F -> no output for the aborted frame, then valid with dout=0F.
